bitonic_share_arbiter: RTL

Shares one bitonic_block sorting unit between NUM_REQ requesters.
- Round-robin arbitration selects a requester and latches its vector.
- The vector is issued to the block with a one-cycle valid pulse; the controller then waits for done.
- The result is returned to the owning requester over a valid/ready response channel.
- A watchdog terminates a transaction if done never arrives; only one transaction is in flight at a time.

---
 rtl/bitonic_pkg.sv | 22 ++
 rtl/bitonic_share_arbiter_rr_arbiter.sv | 35 +++
 rtl/bitonic_share_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic sort-unit arbiter.
//   arb_state_t : controller states (IDLE, ISSUE, WAIT, RESP)
//   t_width     : width of one vector, 2**block_depth elements of data_width bits
//   cnt_width   : width of a watchdog counter able to hold 0..timeout
package bitonic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   function automatic int t_width(input int data_width, input int block_depth);
      return (2 ** block_depth) * data_width;
   endfunction

   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/bitonic_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   ptr     : index of the most recently served requester
//   grant   : one-hot grant of the first requester after ptr (wrapping), or zero
//   any_req : high when any request bit is set
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       any_req
);

   int idx;

   // Scan ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); the first hit wins,
   // so the last served requester has the lowest priority.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!any_req && req[idx]) begin
            grant[idx] = 1'b1;
            any_req    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bitonic_share_arbiter.sv
// Shares one bitonic_block between NUM_REQ requesters, one transaction at a time.
//   clk, reset   : clock, synchronous active-high reset
//   req_valid    : per-requester request valid
//   req_ready    : one-hot (or zero) accept, only in IDLE
//   req_data     : requester i at [i*T_WIDTH +: T_WIDTH]
//   rsp_valid    : one-hot response valid to the owner
//   rsp_ready    : per-requester response ready (only the owner's bit matters)
//   rsp_data     : sorted result (zero on abort), rsp_err: timeout abort flag
//   blk_valid    : one-cycle start pulse, blk_data_in: vector to the block
//   blk_done     : block done, blk_data_out: block result
//   busy         : high outside IDLE
module bitonic_share_arbiter
   import bitonic_pkg::*;
#(
   parameter int  DATA_WIDTH  = 8,
   parameter int  BLOCK_DEPTH = 1,
   parameter int  NUM_REQ     = 4,
   parameter int  TIMEOUT     = 16,
   localparam int T_WIDTH     = t_width(DATA_WIDTH, BLOCK_DEPTH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*T_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [T_WIDTH-1:0]         rsp_data,
   output logic                       rsp_err,
   output logic                       blk_valid,
   output logic [T_WIDTH-1:0]         blk_data_in,
   input  logic                       blk_done,
   input  logic [T_WIDTH-1:0]         blk_data_out,
   output logic                       busy
);

   localparam int PTR_WIDTH = $clog2(NUM_REQ);
   localparam int CNT_WIDTH = cnt_width(TIMEOUT);
   // The counter value after this WAIT cycle would reach TIMEOUT.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   arb_state_t           state, state_next;
   logic [PTR_WIDTH-1:0] ptr, ptr_next;
   logic [PTR_WIDTH-1:0] owner, owner_next;
   logic [PTR_WIDTH-1:0] grant_idx;
   logic [CNT_WIDTH-1:0] cnt, cnt_next;
   logic [T_WIDTH-1:0]   vec_next;
   logic [T_WIDTH-1:0]   rsp_data_next;
   logic                 rsp_err_next;
   logic [NUM_REQ-1:0]   grant;
   logic                 any_req;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req     (req_valid),
      .ptr     (ptr),
      .grant   (grant),
      .any_req (any_req)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = PTR_WIDTH'(i);
         end
      end
   end

   always_comb begin
      state_next    = state;
      ptr_next      = ptr;
      owner_next    = owner;
      cnt_next      = cnt;
      vec_next      = blk_data_in;
      rsp_data_next = rsp_data;
      rsp_err_next  = rsp_err;
      req_ready     = '0;
      rsp_valid     = '0;
      blk_valid     = 1'b0;
      busy          = (state != IDLE);
      case (state)
         IDLE: begin
            // grant only ever selects a requester with req_valid set, so a
            // non-zero grant is itself the handshake.
            req_ready = grant;
            if (any_req) begin
               vec_next   = req_data[int'(grant_idx)*T_WIDTH +: T_WIDTH];
               owner_next = grant_idx;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            blk_valid  = 1'b1;
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            // done is tested first so it wins over a simultaneous timeout.
            if (blk_done) begin
               rsp_data_next = blk_data_out;
               rsp_err_next  = 1'b0;
               state_next    = RESP;
            end else if (cnt == CNT_LAST) begin
               rsp_data_next = '0;
               rsp_err_next  = 1'b1;
               state_next    = RESP;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         RESP: begin
            rsp_valid[owner] = 1'b1;
            if (rsp_ready[owner]) begin
               ptr_next   = owner;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= PTR_WIDTH'(NUM_REQ - 1);
         owner       <= '0;
         cnt         <= '0;
         blk_data_in <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
      end else begin
         state       <= state_next;
         ptr         <= ptr_next;
         owner       <= owner_next;
         cnt         <= cnt_next;
         blk_data_in <= vec_next;
         rsp_data    <= rsp_data_next;
         rsp_err     <= rsp_err_next;
      end
   end

endmodule
